// File: rtl/debug_tx_arbiter.sv
// debug_tx_arbiter: shares one UART byte transmitter between the framed snapshot stream (A) and single-byte replies (B).
// Optional feature macro DEBUG_TX_PREEMPT_EN: lets one B byte slip into an open A frame.
module debug_tx_arbiter #(
    parameter logic [15:0] TIMEOUT_TICKS   = 16'd2000,
    parameter logic [8:0]  MAX_FRAME_BYTES = 9'd260
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       a_req,
    input  logic [7:0] a_data,
    input  logic       a_last,
    output logic       a_ack,
    input  logic       b_req,
    input  logic [7:0] b_data,
    output logic       b_ack,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic       frame_active,
    output logic       err_timeout,
    output logic       err_overlength
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SEND      = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    logic [1:0]  state;
    logic [8:0]  byte_cnt;
    logic [15:0] wd_cnt;
    logic        last_a, cur_a, cur_end, cur_ovl;
    logic        b_ok, grant_a, grant_b, done_ok, wd_expire;

`ifdef DEBUG_TX_PREEMPT_EN
    logic b_ins;
    // B is eligible inside a frame only if it has not already used its slot since the last A byte
    always_comb b_ok = b_req && !(frame_active && b_ins);
    // remember that a B byte was inserted into the open frame
    always_ff @(posedge clk_in) begin
        if (!reset) b_ins <= 1'b0;
        else if (grant_a) b_ins <= 1'b0;
        else if (grant_b) b_ins <= frame_active;
    end
`else
    // B waits for the frame boundary
    always_comb b_ok = b_req && !frame_active;
`endif

    // arbitration: B takes a tie when A was served last or when it may cut into the open frame
    always_comb begin
        grant_a   = state == IDLE && !tx_busy && a_req && !(b_ok && (last_a || frame_active));
        grant_b   = state == IDLE && !tx_busy && b_ok && !grant_a;
        done_ok   = state == WAIT_DONE && tx_done;
        wd_expire = state == WAIT_DONE && !tx_done && wd_cnt + 16'd1 == TIMEOUT_TICKS - 16'd1;
        tx_start  = state == SEND;
    end

    // byte handshake, frame tracking, round-robin pointer and watchdog
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state          <= IDLE;
            tx_data        <= 8'h00;
            a_ack          <= 1'b0;
            b_ack          <= 1'b0;
            frame_active   <= 1'b0;
            err_timeout    <= 1'b0;
            err_overlength <= 1'b0;
            byte_cnt       <= '0;
            wd_cnt         <= '0;
            last_a         <= 1'b0;
            cur_a          <= 1'b0;
            cur_end        <= 1'b0;
            cur_ovl        <= 1'b0;
        end else begin
            a_ack          <= grant_a;
            b_ack          <= grant_b;
            err_timeout    <= wd_expire;
            err_overlength <= done_ok && cur_a && cur_ovl;
            if (grant_a || grant_b) begin
                state   <= SEND;
                tx_data <= grant_a ? a_data : b_data;
                cur_a   <= grant_a;
            end
            if (grant_a) begin
                frame_active <= 1'b1;
                byte_cnt     <= byte_cnt + 9'd1;
                cur_end      <= a_last || byte_cnt == MAX_FRAME_BYTES;
                cur_ovl      <= !a_last && byte_cnt == MAX_FRAME_BYTES;
            end
            if (state == SEND) begin
                state  <= WAIT_DONE;
                wd_cnt <= '0;
            end
            if (done_ok) begin
                state  <= IDLE;
                last_a <= cur_a ? (cur_end || last_a) : 1'b0;
                if (cur_a && cur_end) begin
                    frame_active <= 1'b0;
                    byte_cnt     <= '0;
                end
            end else if (wd_expire) begin
                state        <= IDLE;
                frame_active <= 1'b0;
                byte_cnt     <= '0;
            end else if (state == WAIT_DONE) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_debug_tx_arbiter.sv
// tb_debug_tx_arbiter: directed scenarios with random data and UART latencies, checked against expected byte orders from the arbitration rules.
module tb_debug_tx_arbiter;
    localparam int T = 2000;

    logic       clk_in = 1'b0;
    logic       reset = 1'b0;
    logic       a_req = 1'b0, a_last = 1'b0, b_req = 1'b0;
    logic [7:0] a_data = 8'h00, b_data = 8'h00;
    logic       tx_busy = 1'b0, tx_done = 1'b0;
    logic       a_ack, b_ack, tx_start, frame_active, err_timeout, err_overlength;
    logic [7:0] tx_data;

    always #5 clk_in = ~clk_in;

    debug_tx_arbiter #(.TIMEOUT_TICKS(16'd2000), .MAX_FRAME_BYTES(9'd260)) dut (
        .clk_in(clk_in), .reset(reset),
        .a_req(a_req), .a_data(a_data), .a_last(a_last), .a_ack(a_ack),
        .b_req(b_req), .b_data(b_data), .b_ack(b_ack),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
        .frame_active(frame_active), .err_timeout(err_timeout), .err_overlength(err_overlength)
    );

    int errors = 0, checks = 0, cyc = 0;
    int left = 0, dly_cfg = 0, start_cyc = 0, done_cyc = 0, n_done = 0;
    int watch_idx = -1, watch_cyc = 0, ovl_cnt = 0, ovl_cyc = 0, to_cnt = 0, s = 0, r = 0;
    logic hang = 1'b0, late_done = 1'b0, b_en = 1'b1, watch_pending = 1'b0, fa_at_start = 1'b0;
    logic [7:0] sent[$], exp_q[$], b_q[$];
    logic [8:0] a_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // one clock: protocol invariants, UART model, requester queues
    task automatic tick();
        @(negedge clk_in);
        cyc++;
        if (watch_pending) begin
            chk("fa_after_end", frame_active, 0);
            watch_pending = 1'b0;
        end
        if (a_ack) chk("a_ack_req", a_req, 1);
        if (b_ack) chk("b_ack_req", b_req, 1);
        if (a_ack || b_ack) chk("ack_start", tx_start, 1);
        if (err_timeout || err_overlength) chk("err_no_ack", a_ack | b_ack, 0);
        if (err_timeout) to_cnt++;
        if (err_overlength) begin
            ovl_cnt++;
            ovl_cyc = cyc;
        end
        tx_done = 1'b0;
        if (late_done) begin
            tx_done = 1'b1;
            late_done = 1'b0;
        end
        if (tx_start) begin
            sent.push_back(tx_data);
            start_cyc = cyc;
            fa_at_start = frame_active;
            tx_busy = 1'b1;
            left = dly_cfg > 0 ? dly_cfg : int'($urandom_range(1, 6));
        end else if (tx_busy && !hang) begin
            left--;
            if (left == 0) begin
                tx_done = 1'b1;
                tx_busy = 1'b0;
                n_done++;
                done_cyc = cyc;
                if (n_done == watch_idx) begin
                    chk("fa_at_end", frame_active, 1);
                    watch_pending = 1'b1;
                    watch_cyc = cyc;
                end
            end
        end
        if (a_ack) void'(a_q.pop_front());
        if (b_ack) void'(b_q.pop_front());
        a_req = a_q.size() > 0;
        {a_last, a_data} = a_req ? a_q[0] : 9'h000;
        b_req = b_en && b_q.size() > 0;
        b_data = b_q.size() > 0 ? b_q[0] : 8'h00;
    endtask

    task automatic wait_start(input int lim);
        for (int i = 0; i < lim; i++) begin
            tick();
            if (tx_start) break;
        end
        chk("start_seen", tx_start, 1);
    endtask

    task automatic drain(input int lim);
        for (int i = 0; i < lim && (a_q.size() > 0 || (b_en && b_q.size() > 0) || tx_busy); i++) tick();
        chk("drained", a_q.size() + b_q.size() + int'(tx_busy), 0);
        repeat (3) tick();
    endtask

    task automatic chk_seq(input string tag);
        chk({tag, "_len"}, sent.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < sent.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), sent[i], exp_q[i]);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        hang = 1'b0;
        tx_busy = 1'b0;
        late_done = 1'b0;
        dly_cfg = 0;
        b_en = 1'b1;
        a_q.delete();
        b_q.delete();
        sent.delete();
        exp_q.delete();
        n_done = 0;
        watch_idx = -1;
        watch_pending = 1'b0;
        ovl_cnt = 0;
        to_cnt = 0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_ctl", {a_ack, b_ack, tx_start, frame_active, err_timeout, err_overlength}, 0);
        chk("rst_data", tx_data, 8'h00);
        reset = 1'b1;
        tick();

        // single B byte, slow UART
        dly_cfg = 650;
        b_q.push_back(8'h5A);
        tick();
        tick();
        chk("b1_ack", b_ack, 1);
        chk("b1_start", tx_start, 1);
        chk("b1_data", tx_data, 8'h5A);
        chk("b1_no_a_ack", a_ack, 0);
        b_q.push_back(8'hA5);
        wait_start(1000);
        chk("b1_restart_cyc", cyc, done_cyc + 2);
        chk("b2_data", tx_data, 8'hA5);
        drain(2000);

        // 4-byte A frame, B raised after byte 1
        do_reset();
        for (int i = 1; i <= 4; i++) a_q.push_back({i == 4, 8'(i)});
        b_en = 1'b0;
        b_q.push_back(8'hB7);
`ifdef DEBUG_TX_PREEMPT_EN
        exp_q = '{8'h01, 8'hB7, 8'h02, 8'h03, 8'h04};
        watch_idx = 5;
`else
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hB7};
        watch_idx = 4;
`endif
        for (int i = 0; i < 50 && !a_ack; i++) tick();
        chk("t2_first_ack", a_ack, 1);
        chk("t2_fa_rise", frame_active, 1);
        b_en = 1'b1;
        drain(500);
        chk_seq("t2_seq");
        chk("t2_no_ovl", ovl_cnt, 0);

        // both requesters busy with single-byte A frames: strict alternation from A
        do_reset();
        for (int i = 0; i < 6; i++) begin
            logic [7:0] av, bv;
            av = 8'($urandom);
            bv = 8'($urandom);
            a_q.push_back({1'b1, av});
            b_q.push_back(bv);
            exp_q.push_back(av);
            exp_q.push_back(bv);
        end
        drain(1000);
        chk_seq("t3_alt");

        // hung UART: watchdog, late done ignored, busy blocks regrant
        do_reset();
        hang = 1'b1;
        a_q.push_back({1'b0, 8'h11});
        wait_start(20);
        s = cyc;
        for (int i = 0; i < T + 20 && !err_timeout; i++) tick();
        chk("to_seen", err_timeout, 1);
        chk("to_delay", cyc - s, T);
        chk("to_fa", frame_active, 0);
        late_done = 1'b1;
        b_q.push_back(8'h3C);
        tick();
        chk("to_width", err_timeout, 0);
        repeat (5) tick();
        chk("to_blocked", sent.size(), 1);
        chk("to_one_err", to_cnt, 1);
        hang = 1'b0;
        tx_busy = 1'b0;
        dly_cfg = 3;
        r = cyc;
        wait_start(10);
        chk("to_regrant_cyc", cyc, r + 1);
        chk("to_regrant_data", tx_data, 8'h3C);
        drain(100);
        chk("to_no_more_err", to_cnt, 1);

        // overlength: 261 bytes without a_last, byte 262 opens a new frame
        do_reset();
        for (int i = 0; i < 262; i++) a_q.push_back({i == 261, 8'(i)});
        watch_idx = 261;
        drain(5000);
        chk("ovl_sent", sent.size(), 262);
        chk("ovl_cnt", ovl_cnt, 1);
        chk("ovl_cyc", ovl_cyc, watch_cyc + 1);
        chk("ovl_new_frame", fa_at_start, 1);
        chk("ovl_end_fa", frame_active, 0);

        // reset during WAIT_DONE
        do_reset();
        hang = 1'b1;
        a_q.push_back({1'b0, 8'h77});
        wait_start(20);
        repeat (3) tick();
        chk("mr_fa_before", frame_active, 1);
        reset = 1'b0;
        tick();
        chk("mr_outputs", {a_ack, b_ack, tx_start, frame_active, err_timeout, err_overlength, tx_data}, 0);
        hang = 1'b0;
        tx_busy = 1'b0;
        tick();
        reset = 1'b1;
        repeat (4) tick();
        chk("mr_quiet", {a_ack, b_ack, tx_start, frame_active, err_timeout, err_overlength}, 0);
        chk("mr_no_err", to_cnt + ovl_cnt, 0);
        chk("mr_one_start", sent.size(), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
